// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding and parity modes.
// The parity mode constants are common to the TX frame builder.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // x is the XOR of the data bits and the received parity bit.
    // Mode 3 behaves as even parity.
    function automatic logic par_error(input logic [1:0] mode, input logic x);
        if (mode == PAR_NONE) return 1'b0;
        if (mode == PAR_ODD)  return ~x;
        return x;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw rx pin plus falling-edge detect.
// All flops reset to 1 so a freshly reset idle line never reports an edge.
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic [2:0] ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ff <= 3'b111;
        else          ff <= {ff[1], ff[0], rx};
    end

    assign rx_s    = ff[1];
    assign rx_fall = ff[2] & ~ff[1];

endmodule

// File: rtl/uart_rx_deframe.sv
// UART receive deframer: 16x oversampled start/data/parity/stop sampling.
// Optional break detection output is enabled with UART_RX_BREAK_DETECT_EN.
module uart_rx_deframe
    import uart_pkg::*;
#(
    parameter int OVS   = 16,
    parameter int CNT_W = $clog2(OVS)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_tick,
    input  logic       rx,
    input  logic       d_num,
    input  logic       s_num,
    input  logic [1:0] par,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic       break_det
`endif
);

    rx_state_t        state, state_n;
    logic [CNT_W-1:0] tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [7:0]       data_m;
    logic [1:0]       pmode;
    logic             d8, s2, par_bit, stop_bad;
    logic             rx_s, rx_fall;
    logic             mid, full, last_bit, sample, done;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    assign mid      = s_tick && (tick_cnt == CNT_W'(OVS/2 - 1));
    assign full     = s_tick && (tick_cnt == CNT_W'(OVS - 1));
    assign last_bit = (bit_cnt == (d8 ? 3'd7 : 3'd6));
    assign data_m   = {d8 & shreg[7], shreg[6:0]};
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        sample  = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE:   if (rx_fall) state_n = START;
            START:  if (mid) begin
                        sample  = 1'b1;
                        state_n = rx_s ? IDLE : DATA;
                    end
            DATA:   if (full) begin
                        sample = 1'b1;
                        if (last_bit) state_n = (pmode != PAR_NONE) ? PARITY : STOP;
                    end
            PARITY: if (full) begin
                        sample  = 1'b1;
                        state_n = STOP;
                    end
            STOP:   if (full) begin
                        sample = 1'b1;
                        if (s2) state_n = STOP2;
                        else begin
                            state_n = IDLE;
                            done    = 1'b1;
                        end
                    end
            STOP2:  if (full) begin
                        sample  = 1'b1;
                        state_n = IDLE;
                        done    = 1'b1;
                    end
            default: state_n = IDLE;
        endcase
    end

    // Tick counter restarts at every sample point, so DATA/PARITY/STOP
    // samples land one full bit period after the mid-start sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                      tick_cnt <= '0;
        else if (state == IDLE || sample)  tick_cnt <= '0;
        else if (s_tick)                   tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            pmode      <= PAR_NONE;
            d8         <= 1'b0;
            s2         <= 1'b0;
            par_bit    <= 1'b0;
            stop_bad   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (state == IDLE) begin
                bit_cnt  <= '0;
                stop_bad <= 1'b0;
                if (rx_fall) begin
                    d8    <= d_num;
                    s2    <= s_num;
                    pmode <= par;
                end
            end
            if (sample) begin
                case (state)
                    DATA: begin
                        shreg[bit_cnt] <= rx_s;
                        bit_cnt        <= bit_cnt + 3'd1;
                    end
                    PARITY:  par_bit  <= rx_s;
                    STOP:    stop_bad <= ~rx_s;
                    default: ;
                endcase
            end
            if (done) begin
                data_out   <= data_m;
                parity_err <= par_error(pmode, ^data_m ^ par_bit);
                frame_err  <= stop_bad | ~rx_s;
                data_valid <= 1'b1;
            end
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    // In STOP the first stop sample is on the line now; in STOP2 it was captured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) break_det <= 1'b0;
        else          break_det <= done && (data_m == 8'd0)
                                        && (pmode == PAR_NONE || !par_bit)
                                        && ((state == STOP) ? ~rx_s : stop_bad);
    end
`endif

endmodule

// File: tb/tb_uart_rx_deframe.sv
// Self-checking bench for uart_rx_deframe: table vectors, corner sequences,
// and randomized frames against a frame-level reference model.
module tb_uart_rx_deframe;

    localparam int OVS = 16;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n, s_tick, rx, d_num, s_num;
    logic [1:0] par;
    logic [7:0] data_out;
    logic       data_valid, parity_err, frame_err, busy, break_det;

    int checks = 0;
    int errors = 0;

    uart_rx_deframe #(.OVS(OVS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_tick     (s_tick),
        .rx         (rx),
        .d_num      (d_num),
        .s_num      (s_num),
        .par        (par),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef UART_RX_BREAK_DETECT_EN
        ,
        .break_det  (break_det)
`endif
    );
`ifndef UART_RX_BREAK_DETECT_EN
    assign break_det = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (DIV - 1) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } res_t;

    res_t q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (data_valid) begin
                res_t r;
                r.data = data_out;
                r.perr = parity_err;
                r.ferr = frame_err;
                r.brk  = break_det;
                q.push_back(r);
            end
        end
    end

    typedef struct {
        logic       d8, s2;
        logic [1:0] p;
        logic [7:0] data;
        logic       pbit, st1, st2;
        res_t       exp;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Frame-level expectation straight from the framing rules.
    function automatic res_t model(input logic d8, input logic s2, input logic [1:0] p,
                                   input logic [7:0] data, input logic pbit,
                                   input logic st1, input logic st2);
        res_t r;
        int   ones;
        r.data = d8 ? data : (data & 8'h7f);
        ones   = $countones(r.data) + int'(pbit);
        if (p == 2'd0)      r.perr = 1'b0;
        else if (p == 2'd2) r.perr = (ones % 2 == 0);
        else                r.perr = (ones % 2 == 1);
        r.ferr = !st1 || (s2 && !st2);
        r.brk  = (r.data == 8'd0) && (p == 2'd0 || !pbit) && !st1;
        return r;
    endfunction

    task automatic bit_time();
        repeat (OVS * DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic d8, input logic s2, input logic [1:0] p,
                              input logic [7:0] data, input logic pbit,
                              input logic st1, input logic st2, input bit scramble);
        d_num = d8; s_num = s2; par = p;
        @(negedge clk);
        rx = 1'b0;
        bit_time();
        if (scramble) begin
            d_num = 1'($urandom); s_num = 1'($urandom); par = 2'($urandom);
        end
        for (int i = 0; i < (d8 ? 8 : 7); i++) begin
            rx = data[i];
            bit_time();
        end
        if (p != 2'd0) begin
            rx = pbit;
            bit_time();
        end
        rx = st1;
        bit_time();
        if (s2) begin
            rx = st2;
            bit_time();
        end
        rx = 1'b1;
        bit_time();
    endtask

    task automatic check_frame(input string name, input res_t e);
        res_t r;
        chk({name, "_nvalid"}, q.size(), 1);
        if (q.size() > 0) begin
            r = q.pop_front();
            chk({name, "_data"}, r.data, e.data);
            chk({name, "_perr"}, r.perr, e.perr);
            chk({name, "_ferr"}, r.ferr, e.ferr);
`ifdef UART_RX_BREAK_DETECT_EN
            chk({name, "_brk"}, r.brk, e.brk);
`endif
        end
        q.delete();
        chk({name, "_busy"}, busy, 0);
    endtask

    initial begin
        res_t e;
        tbl[0] = '{1, 0, 2'd0, 8'hA5, 0, 1, 1, '{8'hA5, 0, 0, 0}};
        tbl[1] = '{0, 1, 2'd1, 8'h53, 0, 1, 1, '{8'h53, 0, 0, 0}};
        tbl[2] = '{0, 1, 2'd1, 8'h53, 1, 1, 1, '{8'h53, 1, 0, 0}};
        tbl[3] = '{1, 0, 2'd2, 8'h00, 1, 0, 1, '{8'h00, 0, 1, 0}};
        tbl[4] = '{0, 0, 2'd3, 8'hD3, 1, 1, 1, '{8'h53, 1, 0, 0}};
        tbl[5] = '{1, 1, 2'd1, 8'hFF, 0, 1, 0, '{8'hFF, 0, 1, 0}};
        tbl[6] = '{1, 0, 2'd0, 8'h00, 0, 0, 1, '{8'h00, 0, 1, 1}};
        tbl[7] = '{0, 0, 2'd1, 8'h80, 0, 0, 1, '{8'h00, 0, 1, 1}};
        tbl[8] = '{1, 1, 2'd2, 8'h01, 0, 1, 1, '{8'h01, 0, 0, 0}};

        rx = 1'b1; d_num = 1'b0; s_num = 1'b0; par = 2'd0;
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_outputs", {data_out, data_valid, parity_err, frame_err, busy, break_det}, 0);
        reset_n = 1'b1;
        bit_time();

        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i].d8, tbl[i].s2, tbl[i].p, tbl[i].data,
                       tbl[i].pbit, tbl[i].st1, tbl[i].st2, 1'b0);
            check_frame($sformatf("tbl%0d", i), tbl[i].exp);
        end

        // 4-tick glitch is a false start.
        rx = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        rx = 1'b1;
        chk("glitch_busy_hi", busy, 1);
        repeat ((OVS / 2) * DIV) @(negedge clk);
        chk("glitch_busy_lo", busy, 0);
        chk("glitch_nvalid", q.size(), 0);
        q.delete();
        bit_time();

        // Reset in the middle of data bit 3 of an 8N1 frame.
        d_num = 1'b1; s_num = 1'b0; par = 2'd0;
        rx = 1'b0;
        bit_time();
        rx = 1'b1;
        repeat (3) bit_time();
        repeat (OVS * DIV / 2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_outputs", {data_out, data_valid, parity_err, frame_err, busy, break_det}, 0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) bit_time();
        chk("midreset_nvalid", q.size(), 0);
        q.delete();
        send_frame(1, 0, 2'd0, 8'h3C, 0, 1, 1, 1'b0);
        e = '{8'h3C, 0, 0, 0};
        check_frame("after_reset", e);

        // Line held low for 12 bit times: one break frame, no retrigger.
        d_num = 1'b1; s_num = 1'b0; par = 2'd0;
        rx = 1'b0;
        repeat (12) bit_time();
        e = '{8'h00, 0, 1, 1};
        check_frame("break", e);
        rx = 1'b1;
        bit_time();
        send_frame(1, 0, 2'd0, 8'h5A, 0, 1, 1, 1'b1);
        e = '{8'h5A, 0, 0, 0};
        check_frame("post_break", e);

        for (int n = 0; n < 24; n++) begin
            logic       rd8, rs2, rpb, rst1, rst2;
            logic [1:0] rp;
            logic [7:0] rdata;
            rd8   = 1'($urandom);
            rs2   = 1'($urandom);
            rp    = 2'($urandom);
            rdata = 8'($urandom);
            rpb   = 1'($urandom);
            rst1  = ($urandom_range(0, 3) != 0);
            rst2  = ($urandom_range(0, 3) != 0);
            send_frame(rd8, rs2, rp, rdata, rpb, rst1, rst2, 1'b1);
            check_frame($sformatf("rand%0d", n), model(rd8, rs2, rp, rdata, rpb, rst1, rst2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframe.md
Name: uart_rx_deframe

Overview:
- UART receive path: samples the serial rx line using a 16x oversampling tick and strips start, parity and stop bits.
- Returns the data byte with parity and framing status.
- Counterpart of the TX frame builder. Uses the same configuration inputs (d_num, s_num, par), so both ends of a link share one config register.
- Sits between the rx pad synchroniser domain and the RX FIFO / register interface.

Parameters:
- OVS, 16, oversampling ticks per bit; must be even and ≥ 4.
- CNT_W, $clog2(OVS), width of the tick counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- s_tick  in  1  oversampling strobe, one clk wide, OVS per bit period
- rx  in  1  raw serial input, asynchronous, idle high
- d_num  in  1  1 = 8 data bits, 0 = 7 data bits
- s_num  in  1  1 = 2 stop bits, 0 = 1 stop bit
- par  in  2  0 = none, 1 = even, 2 = odd, 3 = even
- data_out  out  8  received data, LSB first on the wire; bit 7 forced to 0 in 7-bit mode
- data_valid  out  1  one-clk pulse when a frame completes
- parity_err  out  1  parity mismatch for the last frame; 0 when par = 0
- frame_err  out  1  any sampled stop bit was 0 in the last frame
- busy  out  1  high from start detection until the frame completes

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, config latch 0. Reset applied mid-frame aborts the frame with no data_valid.
- rx passes through a 2-FF synchroniser; start detection uses the synchronised falling edge (prev 1, now 0).
- A line stuck low never retriggers; it needs a 1 before the next start.
- d_num, s_num and par are latched at start detection; changes mid-frame have no effect.
- State machine:
  - IDLE: on falling edge go to START; clear tick count.
  - START: count s_tick. At count OVS/2−1 (mid-bit), sample rx.
    - rx = 1: false start, back to IDLE, no outputs change.
    - rx = 0: go to DATA with counts reset.
  - DATA: sample every OVS ticks and shift LSB first. After 7 or 8 bits (latched d_num), go to PARITY if par ≠ 0, else STOP.
  - PARITY: one sample. Even: XOR of data bits and parity bit must be 0. Odd: it must be 1.
  - STOP: one sample. If s_num, a second sample follows OVS ticks later (substate STOP2). frame_err = OR over the stop samples being 0.
- Completion: on the s_tick of the final stop sample, the next clk updates data_out, parity_err and frame_err and pulses data_valid for 1 clk. State returns to IDLE in the same cycle.
- Status outputs hold until the next completed frame.
- Errored frames still deliver data_out and data_valid.
- s_tick is used only as an enable; nothing advances without it.
- busy is 1 in every state except IDLE.

Optional Feature:
- Macro UART_RX_BREAK_DETECT_EN. When defined, adds output break_det (1 bit, reset 0).
- Break condition: all data bits 0, the parity sample (if enabled) 0, and the first stop sample 0.
- On a break, break_det pulses 1 clk together with data_valid; frame_err is also 1.
- Without the macro, the port and its logic are absent and behaviour is otherwise identical.

Decomposition:
- Package uart_pkg holds:
  - state enum rx_state_t {IDLE, START, DATA, PARITY, STOP, STOP2}
  - constants PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2
  - these constants are shared with the TX side
- Sub-module uart_rx_sync: 2-FF synchroniser plus falling-edge detect, with outputs rx_s and rx_fall. Reset value of the flops is 1 (idle line).

Test Plan:
- 8N1, byte 0xA5, OVS = 16 → data_out 0xA5, data_valid 1 pulse, parity_err 0, frame_err 0, busy low afterwards.
- 7E2 (d_num 0, par 1, s_num 1), data 0x53 with parity bit 0 → data_out 0x53, parity_err 0. Repeat with parity bit 1 → parity_err 1.
- 8O1, data 0x00 with parity bit 1 and stop bit 0 → data_out 0x00, parity_err 0, frame_err 1, data_valid pulses.
- rx low pulse of 4 ticks then high (glitch) → false start, no data_valid, busy returns 0 within OVS/2 ticks.
- Assert reset_n low during DATA bit 3 of 8N1 → all outputs 0 immediately. Release reset and send 0x3C → data_out 0x3C received cleanly.
- With UART_RX_BREAK_DETECT_EN: rx held low for 12 bit times in 8N1 → break_det and frame_err pulse with data_valid. No retrigger until rx returns high.
